// File: rtl/dds_profile_sequencer.sv
// dds_profile_sequencer: serial programmer that shifts an init word, then steps through stored DDS profiles
// Ports:
//   ten_MHz_ext_0         clock, all logic on posedge
//   key_2_reset_0         synchronous active-low reset
//   init_start/seq_start  one-cycle start pulses (init wins when both are set)
//   trig_in, use_trig     external dwell advance on trig_in rise when use_trig=1
//   num_prof              profiles to run (1..NPROF, anything else only pulses done)
//   wr_en/wr_addr/wr_data profile RAM write port
//   SDIO/SCLK/CSB         serial port to the DDS, MSB first
//   IO_UPDATE/IO_RESET    DDS update and serial-port reset pulses
//   DR_CTL                digital-ramp direction
//   busy, done, prof_idx  status
// Optional macro SEQ_LOOP_EN adds input seq_loop: wrap to slot 0 after the last dwell.
module dds_profile_sequencer #(
    parameter int WORD_W = 184,
    parameter int NPROF = 12,
    parameter int INIT_W = 232,
    parameter logic [INIT_W-1:0] INIT_WORD = {8'h0b, 32'd0, 32'd0, 128'h0000004000010048002002353fc1c803, 32'd0},
    parameter int CLK_DIV = 2,
    parameter int UPD_W = 8,
    parameter int RST_W = 10,
    parameter int DWELL_CYC = 2000000
) (
    input  logic                       ten_MHz_ext_0,
    input  logic                       key_2_reset_0,
    input  logic                       init_start,
    input  logic                       seq_start,
    input  logic                       trig_in,
    input  logic                       use_trig,
    input  logic [$clog2(NPROF+1)-1:0] num_prof,
    input  logic                       wr_en,
    input  logic [$clog2(NPROF)-1:0]   wr_addr,
    input  logic [WORD_W-1:0]          wr_data,
`ifdef SEQ_LOOP_EN
    input  logic                       seq_loop,
`endif
    output logic                       SDIO,
    output logic                       SCLK,
    output logic                       CSB,
    output logic                       IO_UPDATE,
    output logic                       IO_RESET,
    output logic                       DR_CTL,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NPROF)-1:0]   prof_idx
);
    localparam int AW = $clog2(NPROF);
    localparam int SH_W = (INIT_W > WORD_W) ? INIT_W : WORD_W;
    localparam int BW = $clog2(SH_W + 1);

    typedef enum logic [2:0] {IDLE, RSTP, SHIFT, UPD, DIR, DWELL, DONE} state_t;

    state_t            state;
    logic              is_init;
    logic [WORD_W-1:0] prof_mem [NPROF];
    logic [SH_W-1:0]   shreg;
    logic [BW-1:0]     bits_left;
    logic [31:0]       div;
    logic [31:0]       cnt;
    logic              trig_q;
    logic              dir_up;
    logic              dir_dn;
    logic              loop_on;
    logic              trig_rise;
    logic              prof_ok;
    logic              last;
    logic              dwell_end;
    logic              go_seq;
    logic [AW-1:0]     ld_idx;
    logic [WORD_W-1:0] ld_word;
    logic [31:0]       ld_lo;
    logic [31:0]       ld_hi;

    always_comb begin
`ifdef SEQ_LOOP_EN
        loop_on = seq_loop;
`else
        loop_on = 1'b0;
`endif
        trig_rise = trig_in & ~trig_q;
        prof_ok = (num_prof != '0) && (32'(num_prof) <= 32'(NPROF));
        last = 32'(prof_idx) + 1 >= 32'(num_prof);
        dwell_end = use_trig ? trig_rise : (cnt >= 32'(DWELL_CYC - 1));
        // every entry into a profile shift: a fresh sequence, the next slot, or a loop wrap
        go_seq = (state == IDLE && !init_start && seq_start && prof_ok) ||
                 (state == DWELL && dwell_end && (!last || loop_on));
        ld_idx = (state == DWELL && !last) ? prof_idx + AW'(1) : '0;
        ld_word = prof_mem[ld_idx];
        ld_lo = ld_word[WORD_W-9 -: 32];
        ld_hi = ld_word[WORD_W-41 -: 32];
    end

    always_ff @(posedge ten_MHz_ext_0) begin
        if (wr_en && 32'(wr_addr) < 32'(NPROF)) prof_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge ten_MHz_ext_0) begin
        if (!key_2_reset_0) begin
            state <= IDLE;
            is_init <= 1'b0;
            shreg <= '0;
            bits_left <= '0;
            div <= '0;
            cnt <= '0;
            trig_q <= 1'b0;
            dir_up <= 1'b0;
            dir_dn <= 1'b0;
            SDIO <= 1'b0;
            SCLK <= 1'b0;
            CSB <= 1'b1;
            IO_UPDATE <= 1'b0;
            IO_RESET <= 1'b0;
            DR_CTL <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            prof_idx <= '0;
        end else begin
            trig_q <= trig_in;
            case (state)
                IDLE: begin
                    if (init_start) begin
                        is_init <= 1'b1;
                        busy <= 1'b1;
                        IO_RESET <= 1'b1;
                        cnt <= '0;
                        state <= RSTP;
                    end else if (seq_start) begin
                        is_init <= 1'b0;
                        busy <= 1'b1;
                        if (!prof_ok) begin
                            done <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RSTP: begin
                    if (cnt == 32'(RST_W - 1)) begin
                        IO_RESET <= 1'b0;
                        shreg <= SH_W'(INIT_WORD) << (SH_W - INIT_W);
                        SDIO <= INIT_WORD[INIT_W-1];
                        bits_left <= BW'(INIT_W);
                        div <= '0;
                        CSB <= 1'b0;
                        SCLK <= 1'b0;
                        state <= SHIFT;
                    end else cnt <= cnt + 32'd1;
                end
                SHIFT: begin
                    if (div == 32'(CLK_DIV - 1)) begin
                        div <= '0;
                        if (!SCLK) SCLK <= 1'b1;
                        else if (bits_left == BW'(1)) begin
                            CSB <= 1'b1;
                            SCLK <= 1'b0;
                            SDIO <= 1'b0;
                            IO_UPDATE <= 1'b1;
                            cnt <= '0;
                            state <= UPD;
                        end else begin
                            // next bit goes out at the start of its low half
                            SCLK <= 1'b0;
                            SDIO <= shreg[SH_W-2];
                            shreg <= shreg << 1;
                            bits_left <= bits_left - BW'(1);
                        end
                    end else div <= div + 32'd1;
                end
                UPD: begin
                    if (cnt == 32'(UPD_W - 1)) begin
                        IO_UPDATE <= 1'b0;
                        if (is_init) begin
                            done <= 1'b1;
                            state <= DONE;
                        end else state <= DIR;
                    end else cnt <= cnt + 32'd1;
                end
                DIR: begin
                    DR_CTL <= dir_up ? 1'b1 : dir_dn ? 1'b0 : DR_CTL;
                    cnt <= '0;
                    state <= DWELL;
                end
                DWELL: begin
                    if (!dwell_end) cnt <= cnt + 32'd1;
                    else if (!go_seq) begin
                        done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (go_seq) begin
                // latch the word and its ramp direction now so later RAM writes cannot disturb this profile
                prof_idx <= ld_idx;
                shreg <= SH_W'(ld_word) << (SH_W - WORD_W);
                SDIO <= ld_word[WORD_W-1];
                bits_left <= BW'(WORD_W);
                div <= '0;
                dir_up <= ld_hi > ld_lo;
                dir_dn <= ld_hi < ld_lo;
                CSB <= 1'b0;
                SCLK <= 1'b0;
                state <= SHIFT;
            end
        end
    end
endmodule

// File: tb/tb_dds_profile_sequencer.sv
// tb_dds_profile_sequencer: directed bench with a frame scoreboard for dds_profile_sequencer
module tb_dds_profile_sequencer;
    localparam int WORD_W = 184;
    localparam int INIT_W = 232;
    localparam logic [INIT_W-1:0] INIT_WORD = {8'h0b, 32'd0, 32'd0, 128'h0000004000010048002002353fc1c803, 32'd0};
    localparam logic [WORD_W-1:0] W0 = {8'hA1, 32'd100, 32'd200, 112'h0123456789ABCDEF112233445566};
    localparam logic [WORD_W-1:0] W1 = {8'hB2, 32'd200, 32'd100, 112'hFEDCBA9876543210AABBCCDDEEFF};
    localparam logic [WORD_W-1:0] W1B = {8'hC3, 32'd5, 32'd5, 112'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A};
    localparam logic [WORD_W-1:0] W2 = {8'hD4, 32'd300, 32'd20, 112'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F};
    localparam logic [WORD_W-1:0] W0N = {8'hE5, 32'd50, 32'd10, 112'h0};

    typedef struct {
        int len;
        logic [255:0] data;
    } exp_t;

    logic clk = 0, rst_n = 0, init_start = 0, seq_start = 0, trig_in = 0, use_trig = 0, wr_en = 0;
    logic [3:0] num_prof = 0, wr_addr = 0;
    logic [WORD_W-1:0] wr_data = '0;
    logic SDIO, SCLK, CSB, IO_UPDATE, IO_RESET, DR_CTL, busy, done;
    logic [3:0] prof_idx;

    exp_t sb[$];
    exp_t e_cur;
    int n_chk = 0, n_fail = 0, nbits = 0, low = 0, frames = 0, upd_n = 0, upd_w = 0, rst_w = 0, done_n = 0;
    int f0, u0;
    logic in_frame = 0, sclk_q = 0;
    logic [255:0] fr = '0;

    dds_profile_sequencer #(.DWELL_CYC(50)) dut (
        .ten_MHz_ext_0(clk), .key_2_reset_0(rst_n), .init_start(init_start), .seq_start(seq_start),
        .trig_in(trig_in), .use_trig(use_trig), .num_prof(num_prof), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data),
`ifdef SEQ_LOOP_EN
        .seq_loop(1'b0),
`endif
        .SDIO(SDIO), .SCLK(SCLK), .CSB(CSB), .IO_UPDATE(IO_UPDATE), .IO_RESET(IO_RESET),
        .DR_CTL(DR_CTL), .busy(busy), .done(done), .prof_idx(prof_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [WORD_W-1:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick(1);
        wr_en = 0;
    endtask

    task automatic pulse_seq();
        seq_start = 1;
        tick(1);
        seq_start = 0;
    endtask

    task automatic wait_upd(input string tag, input int budget);
        int u = upd_n;
        for (int k = 0; k < budget && upd_n == u; k++) tick(1);
        check(tag, upd_n - u, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d = done_n;
        for (int k = 0; k < budget && done_n == d; k++) tick(1);
        check({tag, "_pulse"}, {done, busy}, 2'b11);
        tick(1);
        check({tag, "_idle"}, {done, busy}, 2'b00);
        tick(2);
        check({tag, "_count"}, done_n - d, 1);
    endtask

    // scoreboard side: capture SDIO on each SCLK rise while CSB is low, compare at CSB rise
    always @(posedge clk) begin
        #2;
        if (!CSB) begin
            if (!in_frame) begin
                in_frame = 1; nbits = 0; low = 0; fr = '0;
            end
            low++;
            if (SCLK && !sclk_q) begin
                fr = {fr[254:0], SDIO};
                nbits++;
            end
        end else if (in_frame) begin
            in_frame = 0;
            frames++;
            if (sb.size() == 0) check("unexpected_frame", nbits, 0);
            else begin
                e_cur = sb.pop_front();
                if (e_cur.len != 0) begin
                    check("frame_bits", nbits, e_cur.len);
                    check("frame_cycles", low, e_cur.len * 4);
                    check("frame_data", fr, e_cur.data);
                end
            end
        end
        sclk_q = SCLK;
        if (IO_UPDATE) upd_w++;
        else if (upd_w != 0) begin
            check("upd_width", upd_w, 8);
            upd_n++;
            upd_w = 0;
        end
        if (IO_RESET) rst_w++;
        else if (rst_w != 0) begin
            check("rst_width", rst_w, 10);
            rst_w = 0;
        end
        if (done) done_n++;
    end

    initial begin
        tick(3);
        check("reset_outputs", {CSB, SCLK, SDIO, IO_UPDATE, IO_RESET, DR_CTL, busy, done, prof_idx}, {1'b1, 7'b0, 4'd0});
        rst_n = 1;
        tick(2);

        sb.push_back('{INIT_W, 256'(INIT_WORD)});
        init_start = 1;
        tick(1);
        init_start = 0;
        check("init_rstp", {IO_RESET, busy, CSB}, 3'b111);
        wait_done("init_done", 1200);

        wr(4'd0, W0);
        wr(4'd1, W1);
        num_prof = 2; use_trig = 0;
        sb.push_back('{WORD_W, 256'(W0)});
        sb.push_back('{WORD_W, 256'(W1)});
        pulse_seq();
        check("seq_first_slot", {prof_idx, CSB, busy}, {4'd0, 1'b0, 1'b1});
        wait_upd("seq_upd0", 900);
        tick(2);
        check("seq_dir0", {DR_CTL, prof_idx, busy}, {1'b1, 4'd0, 1'b1});
        wait_upd("seq_upd1", 900);
        tick(2);
        check("seq_dir1", {DR_CTL, prof_idx, busy}, {1'b0, 4'd1, 1'b1});
        wait_done("seq_done", 100);

        wr(4'd1, W1B);
        wr(4'd2, W2);
        num_prof = 3; use_trig = 1;
        sb.push_back('{WORD_W, 256'(W0)});
        sb.push_back('{WORD_W, 256'(W1B)});
        sb.push_back('{WORD_W, 256'(W2)});
        pulse_seq();
        wait_upd("trig_upd0", 900);
        tick(200);
        check("trig_hold0", {prof_idx, CSB, busy, DR_CTL}, {4'd0, 3'b111});
        trig_in = 1;
        tick(2);
        check("trig_adv1", {prof_idx, CSB}, {4'd1, 1'b0});
        wait_upd("trig_upd1", 900);
        tick(200);
        check("trig_level_no_adv", {prof_idx, CSB, busy, DR_CTL}, {4'd1, 3'b111});
        trig_in = 0;
        tick(2);
        trig_in = 1;
        tick(2);
        check("trig_adv2", {prof_idx, CSB}, {4'd2, 1'b0});
        trig_in = 0;
        wait_upd("trig_upd2", 900);
        tick(5);
        check("trig_dir2", {DR_CTL, busy}, 2'b01);
        trig_in = 1;
        wait_done("trig_done", 10);
        trig_in = 0;

        use_trig = 0; num_prof = 2;
        sb.push_back('{0, '0});
        pulse_seq();
        for (int k = 0; k < 600 && !(in_frame && nbits >= 50); k++) tick(1);
        check("abort_bit50", nbits, 50);
        u0 = upd_n;
        rst_n = 0;
        tick(1);
        check("abort_state", {CSB, busy, IO_UPDATE, SCLK}, 4'b1000);
        tick(20);
        check("abort_no_upd", upd_n - u0, 0);
        rst_n = 1;
        tick(2);
        num_prof = 1;
        sb.push_back('{WORD_W, 256'(W0)});
        pulse_seq();
        tick(1);
        check("restart_slot0", {prof_idx, CSB}, {4'd0, 1'b0});
        tick(100);
        wr(4'd0, W0N);
        wait_done("restart_done", 1000);
        check("restart_dir_latched", DR_CTL, 1'b1);

        f0 = frames;
        num_prof = 2;
        sb.push_back('{INIT_W, 256'(INIT_WORD)});
        init_start = 1; seq_start = 1;
        tick(1);
        init_start = 0; seq_start = 0;
        check("both_init_wins", {IO_RESET, busy}, 2'b11);
        tick(40);
        pulse_seq();
        wait_done("both_done", 1200);
        tick(100);
        check("busy_start_ignored", {frames - f0, 1'b0 + busy, CSB}, {32'd1, 2'b01});

        num_prof = 0;
        pulse_seq();
        check("np0_done", {done, busy, CSB}, 3'b111);
        tick(1);
        check("np0_idle", {done, busy, CSB}, 3'b001);
        num_prof = 13;
        pulse_seq();
        check("np13_done", {done, busy, CSB}, 3'b111);
        tick(1);
        check("np13_idle", {done, busy, CSB}, 3'b001);
        tick(5);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dds_profile_sequencer.md
Name: dds_profile_sequencer

Overview:
- Parametrised successor to the single-DDS serial programmer.
- Holds NPROF profile words in internal registers, loaded through a write port instead of wide parallel inputs.
- Shifts one init word, then steps through num_prof profiles. Each profile is a serial write, then IO_UPDATE, then a DR_CTL ramp-direction set, then a dwell.
- Sits between the Rabbit register interface and one DDS SPI port. One instance is used per DDS channel.

Parameters:
- WORD_W, 184: profile word width in bits. Sent MSB first.
- NPROF, 12: number of profile slots.
- INIT_W, 232: init word width in bits.
- INIT_WORD, {8'h0b,32'd0,32'd0,128'h0000004000010048002002353fc1c803,32'd0}: init word contents.
- CLK_DIV, 2: clock cycles per SCLK half-period. Must be at least 1.
- UPD_W, 8: IO_UPDATE pulse width in clock cycles.
- RST_W, 10: IO_RESET pulse width in clock cycles.
- DWELL_CYC, 2000000: default dwell per profile in clock cycles (0.2 s at 10 MHz).

Ports:
- ten_MHz_ext_0, in, 1: clock. All logic on posedge.
- key_2_reset_0, in, 1: synchronous active-low reset.
- init_start, in, 1: one-cycle pulse; starts an init write.
- seq_start, in, 1: one-cycle pulse; starts a profile sequence.
- trig_in, in, 1: external advance. Rising edge is detected internally.
- use_trig, in, 1: 1 = the dwell ends on a trig_in rise; 0 = the dwell ends after DWELL_CYC.
- num_prof, in, $clog2(NPROF+1): number of profiles to run, 1..NPROF.
- wr_en, in, 1: profile write strobe.
- wr_addr, in, $clog2(NPROF): profile slot index.
- wr_data, in, WORD_W: profile word.
- SDIO, out, 1: serial data.
- SCLK, out, 1: serial clock.
- CSB, out, 1: chip select, active low.
- IO_UPDATE, out, 1: DDS update pulse.
- IO_RESET, out, 1: DDS serial-port reset pulse.
- DR_CTL, out, 1: digital-ramp direction.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse when a sequence or init completes.
- prof_idx, out, $clog2(NPROF): slot currently active.

Behaviour:
- Reset (key_2_reset_0 low at a clock edge):
  - Outputs: SDIO=0, SCLK=0, CSB=1, IO_UPDATE=0, IO_RESET=0, DR_CTL=0, busy=0, done=0, prof_idx=0.
  - State returns to IDLE and all counters clear.
  - Profile RAM is not cleared.
  - Reset mid-shift aborts the shift. CSB rises on the next edge.
- States: IDLE, RSTP, SHIFT, UPD, DIR, DWELL, DONE.
- IDLE:
  - init_start → RSTP with mode=init.
  - Otherwise seq_start → SHIFT with mode=seq and prof_idx=0.
  - init_start wins if both are asserted in the same cycle.
  - Starts are ignored while busy.
  - seq_start with num_prof=0 or num_prof>NPROF produces a done pulse only, with no serial activity.
- RSTP: IO_RESET high for RST_W cycles, then → SHIFT.
- SHIFT:
  - CSB low. The word is latched at SHIFT entry.
  - Each bit: SCLK low for CLK_DIV cycles with SDIO valid from the first low cycle, then SCLK high for CLK_DIV cycles.
  - Bit i is sent in order from the MSB.
  - Total length: INIT_W or WORD_W bits × 2·CLK_DIV cycles.
  - After the last high half: CSB=1, SCLK=0, SDIO=0 → UPD.
- UPD: IO_UPDATE high for UPD_W cycles.
  - In init mode → DONE.
  - In seq mode → DIR.
- DIR (one cycle):
  - LO = word[WORD_W-9 -: 32], HI = word[WORD_W-41 -: 32].
  - DR_CTL = 1 if HI > LO; DR_CTL = 0 if HI < LO; unchanged if equal.
  - → DWELL.
- DWELL:
  - Ends after DWELL_CYC cycles, or on the first trig_in rise after entry when use_trig=1.
  - If prof_idx+1 < num_prof: prof_idx increments → SHIFT. Otherwise → DONE.
- DONE: done=1 for one cycle → IDLE.
- wr_en writes slot wr_addr on the edge.
  - A write to the slot currently shifting does not affect the shift in progress, because the word is latched at entry.
  - wr_addr ≥ NPROF is ignored.
- Trig edge detector: one flop. A rise is trig_in=1 with previous=0. Its state is not reset by entry to DWELL.

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined: a new input seq_loop (1 bit) is added. When seq_loop=1, after the final dwell the block wraps prof_idx to 0 and returns to SHIFT, with no done pulse. Deasserting seq_loop lets the current pass end normally with DONE.
- Undefined: the port is absent and the sequence always ends after num_prof profiles.

Test Plan:
- Reset with CLK_DIV=2, then init_start → IO_RESET high 10 cycles; CSB low 232×4 = 928 cycles; SDIO bits equal INIT_WORD MSB-first, sampled on SCLK rise; IO_UPDATE high 8 cycles; then done.
- Write slot0 with LO=100 and HI=200, and slot1 with LO=200 and HI=100. Set num_prof=2, use_trig=0, DWELL_CYC=50, then seq_start → two 736-cycle shifts; DR_CTL=1 after slot0 and DR_CTL=0 after slot1; single done pulse; prof_idx goes 0 then 1.
- use_trig=1, num_prof=3 → sequence waits in DWELL indefinitely; each trig_in rise advances exactly one profile; holding trig_in high gives no further advance.
- Drive key_2_reset_0 low at bit 50 of a shift → next edge CSB=1, busy=0, no IO_UPDATE; a following seq_start restarts at slot 0.
- init_start and seq_start in the same cycle → init runs; seq_start pulsed while busy is ignored.
- num_prof=0 → done one cycle after seq_start; CSB stays high.
